// File: rtl/wave_gen.sv
// wave_gen: bounded triangle / sawtooth generator with step, prescaler and
// boundary-applied config handshake. Define WAVEGEN_PERIOD_CNT_EN for period_count.
module wave_gen #(
    parameter int WIDTH     = 8,
    parameter int PRE_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [1:0]           cfg_mode,
    input  logic [WIDTH-1:0]     cfg_min,
    input  logic [WIDTH-1:0]     cfg_max,
    input  logic [WIDTH-1:0]     cfg_step,
    input  logic [PRE_WIDTH-1:0] cfg_prescale,
    output logic [WIDTH-1:0]     value,
    output logic                 direction,
    output logic                 peak,
    output logic                 valley
`ifdef WAVEGEN_PERIOD_CNT_EN
    ,
    output logic [15:0]          period_count
`endif
);

    typedef enum logic [1:0] {
        MODE_TRI = 2'b00,
        MODE_UP  = 2'b01,
        MODE_DN  = 2'b10
    } mode_e;

    mode_e                mode_q, mode_d;
    logic [WIDTH-1:0]     min_q, min_d;
    logic [WIDTH-1:0]     max_q, max_d;
    logic [WIDTH-1:0]     step_q, step_d;
    logic [PRE_WIDTH-1:0] pre_q, pre_d;

    logic                 pend_q, pend_d;
    mode_e                pmode_q, pmode_d;
    logic [WIDTH-1:0]     pmin_q, pmin_d;
    logic [WIDTH-1:0]     pmax_q, pmax_d;
    logic [WIDTH-1:0]     pstep_q, pstep_d;
    logic [PRE_WIDTH-1:0] ppre_q, ppre_d;

    logic [WIDTH-1:0]     value_q, value_d;
    logic                 dir_q, dir_d;
    logic                 peak_q, peak_d;
    logic                 valley_q, valley_d;
    logic [PRE_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic                 applied_q, applied_d;
`ifdef WAVEGEN_PERIOD_CNT_EN
    logic [15:0]          pcnt_q, pcnt_d;
`endif

    logic             xfer;
    logic             tick;
    logic             degen;
    logic             pdegen;
    logic             apply;
    logic             boundary;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   dn_dif;
    logic [WIDTH-1:0] nxt_up;
    logic [WIDTH-1:0] nxt_dn;
    logic [WIDTH-1:0] nv;
    logic             nd;
    mode_e            in_mode;

    // Clamped neighbours of the current value, one extra bit for carry/borrow.
    always_comb begin
        up_sum   = {1'b0, value_q} + {1'b0, step_q};
        dn_dif   = {1'b0, value_q} - {1'b0, step_q};
        nxt_up   = (up_sum > {1'b0, max_q}) ? max_q : up_sum[WIDTH-1:0];
        nxt_dn   = (dn_dif[WIDTH] || (dn_dif[WIDTH-1:0] < min_q))
                 ? min_q : dn_dif[WIDTH-1:0];
        nv       = value_q;
        nd       = dir_q;
        boundary = 1'b0;
        case (mode_q)
            MODE_UP: begin
                nv       = (value_q == max_q) ? min_q : nxt_up;
                nd       = 1'b0;
                boundary = (value_q == max_q);
            end
            MODE_DN: begin
                nv       = (value_q == min_q) ? max_q : nxt_dn;
                nd       = 1'b1;
                boundary = (value_q == min_q);
            end
            default: begin
                if (!dir_q) begin
                    nv = (value_q == max_q) ? nxt_dn : nxt_up;
                    nd = (value_q == max_q);
                end else begin
                    nv = (value_q == min_q) ? nxt_up : nxt_dn;
                    nd = (value_q != min_q);
                end
                boundary = (nv == min_q);
            end
        endcase
    end

    always_comb begin
        mode_d    = mode_q;
        min_d     = min_q;
        max_d     = max_q;
        step_d    = step_q;
        pre_d     = pre_q;
        pend_d    = pend_q;
        pmode_d   = pmode_q;
        pmin_d    = pmin_q;
        pmax_d    = pmax_q;
        pstep_d   = pstep_q;
        ppre_d    = ppre_q;
        value_d   = value_q;
        dir_d     = dir_q;
        peak_d    = 1'b0;
        valley_d  = 1'b0;
        cnt_d     = cnt_q;
        ready_d   = ready_q;
        applied_d = 1'b0;
`ifdef WAVEGEN_PERIOD_CNT_EN
        pcnt_d    = pcnt_q;
`endif
        in_mode = (cfg_mode == 2'b11) ? MODE_TRI : mode_e'(cfg_mode);
        xfer    = cfg_valid & ready_q;
        tick    = enable & (cnt_q == pre_q);
        degen   = (min_q >= max_q);
        pdegen  = (pmin_q >= pmax_q);
        apply   = pend_q & (~enable | degen | (tick & boundary));

        if (enable) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
        if (applied_q) begin
            ready_d = 1'b1;
        end
        if (xfer) begin
            pend_d  = 1'b1;
            pmode_d = in_mode;
            pmin_d  = cfg_min;
            pmax_d  = cfg_max;
            pstep_d = (cfg_step == '0) ? WIDTH'(1) : cfg_step;
            ppre_d  = cfg_prescale;
            ready_d = 1'b0;
        end

        if (apply) begin
            mode_d    = pmode_q;
            min_d     = pmin_q;
            max_d     = pmax_q;
            step_d    = pstep_q;
            pre_d     = ppre_q;
            pend_d    = 1'b0;
            applied_d = 1'b1;
            cnt_d     = '0;
            dir_d     = (pmode_q == MODE_DN) && !pdegen;
            value_d   = dir_d ? pmax_q : pmin_q;
`ifdef WAVEGEN_PERIOD_CNT_EN
            pcnt_d    = '0;
`endif
        end else if (degen) begin
            value_d = min_q;
            dir_d   = 1'b0;
        end else if (tick) begin
            value_d  = nv;
            dir_d    = nd;
            peak_d   = (nv == max_q);
            valley_d = (nv == min_q);
`ifdef WAVEGEN_PERIOD_CNT_EN
            if (boundary) begin
                pcnt_d = pcnt_q + 16'd1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= MODE_TRI;
            min_q     <= '0;
            max_q     <= '1;
            step_q    <= WIDTH'(1);
            pre_q     <= '0;
            pend_q    <= 1'b0;
            pmode_q   <= MODE_TRI;
            pmin_q    <= '0;
            pmax_q    <= '0;
            pstep_q   <= '0;
            ppre_q    <= '0;
            value_q   <= '0;
            dir_q     <= 1'b0;
            peak_q    <= 1'b0;
            valley_q  <= 1'b0;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            applied_q <= 1'b0;
`ifdef WAVEGEN_PERIOD_CNT_EN
            pcnt_q    <= '0;
`endif
        end else begin
            mode_q    <= mode_d;
            min_q     <= min_d;
            max_q     <= max_d;
            step_q    <= step_d;
            pre_q     <= pre_d;
            pend_q    <= pend_d;
            pmode_q   <= pmode_d;
            pmin_q    <= pmin_d;
            pmax_q    <= pmax_d;
            pstep_q   <= pstep_d;
            ppre_q    <= ppre_d;
            value_q   <= value_d;
            dir_q     <= dir_d;
            peak_q    <= peak_d;
            valley_q  <= valley_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            applied_q <= applied_d;
`ifdef WAVEGEN_PERIOD_CNT_EN
            pcnt_q    <= pcnt_d;
`endif
        end
    end

    assign cfg_ready = ready_q;
    assign value     = value_q;
    assign direction = dir_q;
    assign peak      = peak_q;
    assign valley    = valley_q;
`ifdef WAVEGEN_PERIOD_CNT_EN
    assign period_count = pcnt_q;
`endif

endmodule

// File: tb/tb_wave_gen.sv
// tb_wave_gen: table vectors, corner sequences and random stimulus checked
// against a period-sequence reference model of wave_gen.
module tb_wave_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_mode = 2'b00;
    logic [7:0] cfg_min = 8'd0;
    logic [7:0] cfg_max = 8'd0;
    logic [7:0] cfg_step = 8'd0;
    logic [7:0] cfg_prescale = 8'd0;
    logic [7:0] value;
    logic       direction;
    logic       peak;
    logic       valley;
`ifdef WAVEGEN_PERIOD_CNT_EN
    logic [15:0] period_count;
`endif

    always #5 clk = ~clk;

    wave_gen #(.WIDTH(8), .PRE_WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_mode(cfg_mode),
        .cfg_min(cfg_min),
        .cfg_max(cfg_max),
        .cfg_step(cfg_step),
        .cfg_prescale(cfg_prescale),
        .value(value),
        .direction(direction),
        .peak(peak),
        .valley(valley)
`ifdef WAVEGEN_PERIOD_CNT_EN
        ,
        .period_count(period_count)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one period of (value, direction) precomputed as a list.
    int m_mode, m_min, m_max, m_step, m_pre;
    int p_mode, p_min, p_max, p_step, p_pre;
    bit m_pend, m_ready, m_applied;
    int m_cnt, m_idx, m_pc, m_value;
    bit m_dir, m_peak, m_valley;
    int sv[$];
    bit sd[$];

    typedef struct {
        logic [1:0] mode;
        int mn;
        int mx;
        int st;
        int pr;
        int exp[10];
    } vec_t;
    vec_t tbl[5];

    task chk(input string nm, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task build();
        int v;
        sv.delete();
        sd.delete();
        if (m_min >= m_max) begin
            sv.push_back(m_min);
            sd.push_back(1'b0);
        end else if (m_mode == 2) begin
            v = m_max;
            sv.push_back(v);
            sd.push_back(1'b1);
            while (v != m_min) begin
                v = (v - m_step < m_min) ? m_min : v - m_step;
                sv.push_back(v);
                sd.push_back(1'b1);
            end
        end else begin
            v = m_min;
            sv.push_back(v);
            sd.push_back(m_mode == 0);
            while (v != m_max) begin
                v = (v + m_step > m_max) ? m_max : v + m_step;
                sv.push_back(v);
                sd.push_back(1'b0);
            end
            if (m_mode == 0) begin
                v = (v - m_step < m_min) ? m_min : v - m_step;
                while (v != m_min) begin
                    sv.push_back(v);
                    sd.push_back(1'b1);
                    v = (v - m_step < m_min) ? m_min : v - m_step;
                end
            end
        end
    endtask

    task model_reset();
        m_mode = 0; m_min = 0; m_max = 255; m_step = 1; m_pre = 0;
        m_pend = 0; m_ready = 1; m_applied = 0;
        m_cnt = 0; m_idx = 0; m_pc = 0; m_value = 0;
        m_dir = 0; m_peak = 0; m_valley = 0;
        build();
    endtask

    task model_step();
        bit tk, wrap, ap, xf, nr;
        if (rst) begin
            model_reset();
        end else begin
            xf = cfg_valid && m_ready;
            tk = enable && (m_cnt == m_pre);
            if (enable) m_cnt = tk ? 0 : m_cnt + 1;
            wrap = tk && (m_min < m_max) && (((m_idx + 1) % sv.size()) == 0);
            ap = m_pend && (!enable || (m_min >= m_max) || wrap);
            nr = m_applied ? 1'b1 : m_ready;
            m_applied = 0;
            m_peak = 0;
            m_valley = 0;
            if (ap) begin
                m_mode = p_mode; m_min = p_min; m_max = p_max;
                m_step = p_step; m_pre = p_pre;
                build();
                m_idx = 0;
                m_value = sv[0];
                m_dir = (m_mode == 2) && (m_min < m_max);
                m_cnt = 0; m_pc = 0; m_pend = 0; m_applied = 1;
            end else if (tk && (m_min < m_max)) begin
                m_idx = (m_idx + 1) % sv.size();
                m_value = sv[m_idx];
                m_dir = sd[m_idx];
                m_peak = (m_value == m_max);
                m_valley = (m_value == m_min);
                if (m_idx == 0) m_pc = (m_pc + 1) % 65536;
            end
            if (xf) begin
                m_pend = 1;
                p_mode = (cfg_mode == 2'b11) ? 0 : int'(cfg_mode);
                p_min = cfg_min;
                p_max = cfg_max;
                p_step = (cfg_step == 0) ? 1 : int'(cfg_step);
                p_pre = cfg_prescale;
                nr = 0;
            end
            m_ready = nr;
        end
    endtask

    task check_all();
        chk("value", value, m_value);
        chk("direction", direction, m_dir);
        chk("peak", peak, m_peak);
        chk("valley", valley, m_valley);
        chk("cfg_ready", cfg_ready, m_ready);
`ifdef WAVEGEN_PERIOD_CNT_EN
        chk("period_count", period_count, m_pc);
`endif
    endtask

    task cyc();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        @(negedge clk);
    endtask

    task load_cfg(input logic [1:0] md, input int mn, input int mx,
                  input int st, input int pr);
        enable = 1'b0;
        for (int i = 0; i < 10 && !cfg_ready; i++) cyc();
        cfg_valid = 1'b1;
        cfg_mode = md;
        cfg_min = 8'(mn);
        cfg_max = 8'(mx);
        cfg_step = 8'(st);
        cfg_prescale = 8'(pr);
        cyc();
        cfg_valid = 1'b0;
        cyc();
        cyc();
    endtask

    initial begin
        logic found;
        int mn, mx;

        tbl[0].mode = 2'b00; tbl[0].mn = 10; tbl[0].mx = 20; tbl[0].st = 3; tbl[0].pr = 0;
        tbl[0].exp = '{10, 13, 16, 19, 20, 17, 14, 11, 10, 13};
        tbl[1].mode = 2'b01; tbl[1].mn = 0; tbl[1].mx = 9; tbl[1].st = 4; tbl[1].pr = 2;
        tbl[1].exp = '{0, 4, 8, 9, 0, 4, 8, 9, 0, 4};
        tbl[2].mode = 2'b10; tbl[2].mn = 5; tbl[2].mx = 15; tbl[2].st = 4; tbl[2].pr = 1;
        tbl[2].exp = '{15, 11, 7, 5, 15, 11, 7, 5, 15, 11};
        tbl[3].mode = 2'b00; tbl[3].mn = 3; tbl[3].mx = 5; tbl[3].st = 0; tbl[3].pr = 0;
        tbl[3].exp = '{3, 4, 5, 4, 3, 4, 5, 4, 3, 4};
        tbl[4].mode = 2'b11; tbl[4].mn = 0; tbl[4].mx = 4; tbl[4].st = 2; tbl[4].pr = 0;
        tbl[4].exp = '{0, 2, 4, 2, 0, 2, 4, 2, 0, 2};

        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cyc();
        chk("rst_value", value, 0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_peak", peak, 0);
        chk("rst_valley", valley, 0);
        rst = 1'b0;

        enable = 1'b1;
        for (int i = 1; i <= 511; i++) begin
            cyc();
            if (i == 255) begin
                chk("legacy_top", value, 255);
                chk("legacy_peak", peak, 1);
            end
            if (i == 510) begin
                chk("legacy_bottom", value, 0);
                chk("legacy_valley", valley, 1);
            end
        end

        for (int k = 0; k < 5; k++) begin
            load_cfg(tbl[k].mode, tbl[k].mn, tbl[k].mx, tbl[k].st, tbl[k].pr);
            enable = 1'b1;
            for (int j = 0; j < 10; j++) begin
                chk("tbl_value", value, tbl[k].exp[j]);
                for (int c = 0; c <= tbl[k].pr; c++) cyc();
            end
            enable = 1'b0;
        end

        load_cfg(2'b00, 10, 20, 3, 0);
        enable = 1'b1;
        cyc();
        cyc();
        cfg_valid = 1'b1;
        cfg_mode = 2'b01; cfg_min = 8'd30; cfg_max = 8'd40;
        cfg_step = 8'd5; cfg_prescale = 8'd0;
        cyc();
        chk("hs_ready_low", cfg_ready, 0);
        cfg_mode = 2'b10; cfg_min = 8'd100; cfg_max = 8'd120; cfg_step = 8'd7;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (value == 8'd30) begin
                found = 1'b1;
                break;
            end
        end
        chk("hs_applied", found, 1);
        chk("hs_ready_still_low", cfg_ready, 0);
        cyc();
        chk("hs_ready_back", cfg_ready, 1);
        chk("hs_first_bundle", value, 35);
        cyc();
        cfg_valid = 1'b0;
        chk("hs_second_xfer", cfg_ready, 0);
        cyc();
        chk("hs_second_apply", value, 120);
        for (int i = 0; i < 10; i++) cyc();

        load_cfg(2'b00, 50, 50, 1, 0);
        chk("degen_value", value, 50);
        enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("degen_hold", value, 50);
            chk("degen_no_peak", peak, 0);
            chk("degen_no_valley", valley, 0);
        end

        load_cfg(2'b00, 10, 20, 3, 0);
        enable = 1'b1;
        cfg_valid = 1'b1;
        cfg_mode = 2'b01; cfg_min = 8'd0; cfg_max = 8'd5;
        cyc();
        cfg_valid = 1'b0;
        chk("rp_pending", cfg_ready, 0);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rp_value", value, 0);
        chk("rp_ready", cfg_ready, 1);
        for (int i = 0; i < 5; i++) cyc();
        chk("rp_resume", value, 5);

        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            enable = ($urandom_range(0, 9) != 0);
            cfg_valid = ($urandom_range(0, 29) == 0);
            if (cfg_valid) begin
                mn = $urandom_range(0, 255);
                if ($urandom_range(0, 7) == 0) mx = $urandom_range(0, 255);
                else mx = mn + $urandom_range(1, 40);
                if (mx > 255) mx = 255;
                cfg_mode = 2'($urandom_range(0, 3));
                cfg_min = 8'(mn);
                cfg_max = 8'(mx);
                cfg_step = 8'($urandom_range(0, 9));
                cfg_prescale = 8'($urandom_range(0, 3));
            end
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
